// File: rtl/blink_seq_pkg.sv
// Shared types and helpers for the LED blink sequencer.
//   state_t      : sequencer FSM states
//   presc_width  : counter width needed for a modulo-DIV prescaler
package blink_seq_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  localparam int unsigned TickDivDefault = 1000;

  // Width of a counter spanning 0..div-1; never less than one bit.
  function automatic int unsigned presc_width(int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  localparam int unsigned PrescWDefault = presc_width(TickDivDefault);

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV up-counter producing one tick per DIV clock cycles.
//   clk  : clock
//   rst  : asynchronous active-high reset (count to 0)
//   clr  : synchronous clear, takes priority over counting
//   tick : high while the count equals DIV-1
module tick_prescaler
  import blink_seq_pkg::*;
#(
  parameter int unsigned DIV = TickDivDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = presc_width(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/blink_sequencer.sv
// Sequences an LED through reps ON/OFF pairs, each phase a whole number of
// prescaled ticks, with a start/busy/done handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   abort               : cancels an active ON/OFF sequence
//   on_ticks, off_ticks : phase lengths in ticks (0 behaves as 1)
//   reps                : number of ON+OFF pairs (0 goes straight to DONE)
//   led, busy, done     : registered outputs
module blink_sequencer
  import blink_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DUR_W-1:0] on_ticks,
  input  logic [DUR_W-1:0] off_ticks,
  input  logic [REP_W-1:0] reps,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] on_q, on_d;
  logic [DUR_W-1:0] off_q, off_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [DUR_W-1:0] phase_q, phase_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic             presc_clr;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    rem_d   = rem_q;
    phase_d = phase_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          on_d    = (on_ticks == '0) ? DUR_W'(1) : on_ticks;
          off_d   = (off_ticks == '0) ? DUR_W'(1) : off_ticks;
          rem_d   = reps;
          state_d = (reps != '0) ? ON : DONE;
        end
      end
      ON: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          if (phase_q == on_q - DUR_W'(1)) begin
            state_d = OFF;
          end else begin
            phase_d = phase_q + DUR_W'(1);
          end
        end
      end
      OFF: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          if (phase_q == off_q - DUR_W'(1)) begin
            rem_d   = rem_q - REP_W'(1);
            state_d = (rem_d != '0) ? ON : DONE;
          end else begin
            phase_d = phase_q + DUR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart tick timing on every phase boundary so phases are exact.
    presc_clr = (state_d != state_q);
    if (presc_clr) begin
      phase_d = '0;
    end

    // Outputs are registered from the next state, so they align with it.
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      on_q    <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with TICK_DIV=4. Expected outputs
// per cycle come from the timing rules: a sequence of reps periods of
// (on'+off')*TICK_DIV cycles, then one DONE cycle.
module tb_blink_sequencer;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] on_ticks;
  logic [7:0] off_ticks;
  logic [3:0] reps;
  logic       led;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blink_sequencer #(
    .TICK_DIV (TickDiv),
    .DUR_W    (8),
    .REP_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .on_ticks  (on_ticks),
    .off_ticks (off_ticks),
    .reps      (reps),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // {led, busy, done} expected in cycle c after the start-accept edge.
  function automatic logic [2:0] expect_at(input int c, input int on, input int off,
                                           input int nreps, input int abort_at);
    int onc;
    int per;
    int t;
    onc = clampd(on) * TickDiv;
    per = onc + clampd(off) * TickDiv;
    t   = nreps * per;
    if (abort_at > 0 && abort_at <= t && c > abort_at) return 3'b000;
    if (c < 1 || c > t + 1) return 3'b000;
    if (c == t + 1) return 3'b011;
    return (((c - 1) % per) < onc) ? 3'b110 : 3'b010;
  endfunction

  // Called at a negedge with the DUT idle: start is sampled at the next edge.
  // junk_at: cycle in which a stray start with random config is driven.
  // abort_at: cycle in which abort is driven.
  task automatic run_seq(input string name, input int on, input int off, input int nreps,
                         input int junk_at, input int abort_at);
    int t;
    int n;
    logic [2:0] act;
    logic [2:0] exp;
    t = nreps * (clampd(on) + clampd(off)) * TickDiv;
    n = (abort_at > 0 && abort_at <= t) ? abort_at + 1 : t + 2;
    start     = 1'b1;
    abort     = 1'b0;
    on_ticks  = 8'(on);
    off_ticks = 8'(off);
    reps      = 4'(nreps);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      act = {led, busy, done};
      exp = expect_at(c, on, off, nreps, abort_at);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: led/busy/done=%b expected %b", name, c, act, exp);
      end
      start     = (c == junk_at) && (c <= t + 1);
      abort     = (c == abort_at);
      on_ticks  = 8'($urandom_range(0, 255));
      off_ticks = 8'($urandom_range(0, 255));
      reps      = 4'($urandom_range(0, 15));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    on_ticks  = '0;
    off_ticks = '0;
    reps      = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({led, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: led/busy/done=%b expected 000", {led, busy, done});
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL idle cycle %0d: led/busy/done=%b expected 000", i, {led, busy, done});
      end
    end
    run_seq("reps0", 3, 2, 0, 0, 0);
    // abort arriving during DONE must not cut the pulse short
    run_seq("reps0_abort_in_done", 1, 1, 0, 0, 1);
  endtask

  task automatic test_pattern();
    run_seq("pattern", 2, 3, 2, 0, 0);
  endtask

  task automatic test_clamp();
    run_seq("clamp", 0, 0, 1, 0, 0);
  endtask

  task automatic test_start_ignored();
    run_seq("start_ignored", 2, 3, 2, 10, 0);
  endtask

  task automatic test_abort();
    run_seq("abort", 2, 3, 2, 0, 15);
    @(negedge clk);
    checks++;
    if ({led, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle cycle 17: led/busy/done=%b expected 000", {led, busy, done});
    end
    run_seq("after_abort", 1, 2, 1, 0, 0);
    // abort and start together in IDLE: nothing starts
    start     = 1'b1;
    abort     = 1'b1;
    on_ticks  = 8'd2;
    off_ticks = 8'd2;
    reps      = 4'd1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if ({led, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL start_abort_idle cycle %0d: led/busy/done=%b expected 000",
                 i, {led, busy, done});
      end
    end
  endtask

  task automatic test_async_reset();
    start     = 1'b1;
    on_ticks  = 8'd2;
    off_ticks = 8'd3;
    reps      = 4'd2;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({led, busy} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_on: led/busy=%b expected 11", {led, busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({led, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: led/busy/done=%b expected 000", {led, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({led, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset: led/busy/done=%b expected 000", {led, busy, done});
    end
    run_seq("after_reset", 1, 1, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    int on;
    int off;
    int nr;
    int t;
    int junk;
    int ab;
    for (int i = 0; i < 10; i++) begin
      on   = int'($urandom_range(0, 3));
      off  = int'($urandom_range(0, 3));
      nr   = int'($urandom_range(0, 3));
      t    = nr * (clampd(on) + clampd(off)) * TickDiv;
      junk = int'($urandom_range(0, t + 1));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, t + 1)) : 0;
      run_seq("random", on, off, nr, junk, ab);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_clamp();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Controller that sequences an LED through a programmed blink pattern: N repetitions of an ON phase and an OFF phase, each a whole number of prescaled ticks. It owns a tick prescaler (a mod-TICK_DIV counter) and restarts it at every phase boundary so phase lengths are exact. It sits between the top-level start/config registers and the board LED pin, with a start/busy/done handshake toward the requester.

## Interface
- TICK_DIV, default 1000: clk cycles per tick; legal range ≥ 2.
- DUR_W, default 8: width of the phase-duration inputs, in ticks.
- REP_W, default 4: width of the repetition count.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel of an active sequence
- on_ticks  in  DUR_W  ON-phase length in ticks; 0 is treated as 1
- off_ticks  in  DUR_W  OFF-phase length in ticks; 0 is treated as 1
- reps  in  REP_W  number of ON+OFF pairs; 0 is legal
- led  out  1  LED drive, registered
- busy  out  1  high while a sequence is active, including the DONE cycle
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ON, OFF, DONE.
- Reset values: state IDLE, led 0, busy 0, done 0, prescaler 0, all latched config 0.
- IDLE with start=1 and abort=0:
  - latch on_ticks, off_ticks and reps; clamp each zero duration to 1.
  - next state is ON if reps≠0, otherwise DONE.
- The config inputs are ignored outside the start cycle. start is ignored in every non-IDLE state.
- ON: led=1.
  - Count ticks. After on_ticks ticks, go to OFF.
- OFF: led=0.
  - After off_ticks ticks, decrement the remaining-rep count.
  - Go to ON if the count is still nonzero, otherwise go to DONE.
- DONE: done=1, busy=1, led=0. Lasts exactly one cycle, then IDLE.
- abort=1 in ON or OFF: next state IDLE, led=0, busy=0, no done pulse.
- abort in DONE is ignored; the pulse completes.
- abort and start together in IDLE: abort wins, start is discarded.
- Prescaler: counts 0..TICK_DIV-1 and emits tick when it wraps.
  - It is synchronously cleared on every state transition, so each phase begins with a full tick period.
  - The phase tick counter is DUR_W bits wide, with no overflow possible: max value 2^DUR_W-1.
- Reset asserted mid-sequence drives all outputs to their reset values immediately. No done is produced.

## Timing
- Take the start-accept edge as cycle 0.
- Let P = (on'+off')·TICK_DIV, where on' and off' are the clamped durations, and let T = reps·P.
- Cycle ranges:
  - led=1 during cycles 1..on'·TICK_DIV of each pair.
  - busy=1 during cycles 1..T+1.
  - done=1 only in cycle T+1.
  - IDLE is re-entered at cycle T+2, where a new start is accepted.
- reps=0: busy and done are both high in cycle 1 only; led stays 0.
- abort sampled high at edge k: led, busy and state are all cleared by cycle k+1.
- All outputs come straight from flops; there is no combinational path from input to output.

## Structure
- Package blink_seq_pkg holds:
  - typedef enum state_t {IDLE, ON, OFF, DONE}.
  - a localparam helper for the prescaler width, $clog2(TICK_DIV).
- Sub-module tick_prescaler, with parameter DIV and ports clk, rst, clr, tick.
  - Modulo-DIV up-counter.
  - clr has priority over counting.
  - tick is high in the cycle the count equals DIV-1.
- Top level: FSM plus phase-tick and rep counters.

## Test plan
Run every scenario with TICK_DIV=4.
- Reset, then idle for 20 cycles → led=busy=done=0; start with reps=0 → busy and done high in cycle 1 only, led never rises.
- on=2, off=3, reps=2, start at cycle 0 → led high in cycles 1–8 and 21–28; done only in cycle 41; busy in cycles 1–41.
- on=0, off=0, reps=1 → durations clamped to 1; led high in cycles 1–4; done in cycle 9.
- Pulse start again in cycle 10 of the second scenario, with different config → ignored; the waveform matches the second scenario exactly.
- abort in cycle 15 of the second scenario → led, busy=0 from cycle 16; no done pulse; a fresh start in cycle 17 is accepted.
- Assert rst asynchronously mid-ON → led and busy drop without waiting for a clk edge; after release the block is IDLE and accepts a start.
